// File: rtl/ptr_reg_bank.sv
// ptr_reg_bank
// Bank of NUM_REGS pointer registers, each split into a low and a high
// half of BYTE_W bits. Supports byte/word loads, full-width INC/DEC and
// indexed add of an unsigned (IDXU) or signed (IDXS) offset to the low byte.
//
// Build option PTR_BANK_FIXUP_EN:
//   defined   - a carry/borrow out of the low byte on IDX* is applied to the
//               high byte in a second FIXUP cycle (6502-style timing). During
//               that cycle op_ready is low and the register shows the
//               dummy-read address (corrected low, uncorrected high).
//   undefined - IDX* performs the full-width add in one cycle; op_ready is
//               tied high and busy_sel tied to 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   op_valid, op_ready  operation handshake (accept = op_valid & op_ready)
//   op                  0 NOP,1 LDL,2 LDH,3 LDW,4 INC,5 DEC,6 IDXU,7 IDXS
//   wr_sel              target register (>= NUM_REGS: accepted, no effect)
//   din_l, din_h        load data
//   offset              index offset for IDXU/IDXS
//   rd_sel              register shown on addr_l/addr_h (combinational)
//   addr_l, addr_h      selected register halves
//   page_cross          one-cycle pulse after an IDX* crossing a page
//   busy_sel            register under fix-up, 0 when idle
module ptr_reg_bank #(
    parameter int NUM_REGS = 3,
    parameter int BYTE_W   = 8,
    parameter int SEL_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [BYTE_W-1:0] din_l,
    input  logic [BYTE_W-1:0] din_h,
    input  logic [BYTE_W-1:0] offset,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [BYTE_W-1:0] addr_l,
    output logic [BYTE_W-1:0] addr_h,
    output logic              page_cross,
    output logic [SEL_W-1:0]  busy_sel
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDL  = 3'd1;
    localparam logic [2:0] OP_LDH  = 3'd2;
    localparam logic [2:0] OP_LDW  = 3'd3;
    localparam logic [2:0] OP_INC  = 3'd4;
    localparam logic [2:0] OP_DEC  = 3'd5;
    localparam logic [2:0] OP_IDXU = 3'd6;
    localparam logic [2:0] OP_IDXS = 3'd7;

    localparam int PTR_W = 2 * BYTE_W;

    // Offset widened to the full pointer width: sign-extended for IDXS,
    // zero-extended for IDXU.
    function automatic logic signed [PTR_W-1:0] extend_offset(
        input logic [BYTE_W-1:0] off,
        input logic              is_signed
    );
        logic sign_bit;
        sign_bit = is_signed & off[BYTE_W-1];
        return {{BYTE_W{sign_bit}}, off};
    endfunction

    logic [BYTE_W-1:0] reg_l [NUM_REGS];
    logic [BYTE_W-1:0] reg_h [NUM_REGS];

    logic              accept;
    logic              sel_ok;
    logic [BYTE_W-1:0] cur_l;
    logic [BYTE_W-1:0] cur_h;
    logic [BYTE_W-1:0] nxt_l;
    logic [BYTE_W-1:0] nxt_h;
    logic [BYTE_W:0]   sum_l;
    logic              is_idx;
    logic              off_neg;
    logic              cross_up;
    logic              cross_dn;
    logic              crossing;
    logic              page_cross_p1;

    assign accept = op_valid & op_ready;
    assign sel_ok = (32'(wr_sel) < NUM_REGS);
    assign is_idx = (op == OP_IDXU) || (op == OP_IDXS);

    // Current contents of the write target (0 when out of range).
    always_comb begin
        cur_l = '0;
        cur_h = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_sel == SEL_W'(i)) begin
                cur_l = reg_l[i];
                cur_h = reg_h[i];
            end
        end
    end

    // Read port: zero-latency view of rd_sel.
    always_comb begin
        addr_l = '0;
        addr_h = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                addr_l = reg_l[i];
                addr_h = reg_h[i];
            end
        end
    end

    // Low-byte carry detection. A negative offset always produces an
    // unsigned carry unless the result wrapped below zero, so "no carry"
    // with a negative offset is a borrow.
    assign sum_l    = {1'b0, cur_l} + {1'b0, offset};
    assign off_neg  = (op == OP_IDXS) & offset[BYTE_W-1];
    assign cross_up = sum_l[BYTE_W] & ~off_neg;
    assign cross_dn = ~sum_l[BYTE_W] & off_neg;
    assign crossing = is_idx & (cross_up | cross_dn);

    always_comb begin
        logic [PTR_W-1:0] full;
        nxt_l = cur_l;
        nxt_h = cur_h;
        full  = {cur_h, cur_l};
        case (op)
            OP_LDL: nxt_l = din_l;
            OP_LDH: nxt_h = din_h;
            OP_LDW: begin
                nxt_l = din_l;
                nxt_h = din_h;
            end
            OP_INC: {nxt_h, nxt_l} = full + PTR_W'(1);
            OP_DEC: {nxt_h, nxt_l} = full - PTR_W'(1);
            OP_IDXU, OP_IDXS: begin
`ifdef PTR_BANK_FIXUP_EN
                nxt_l = sum_l[BYTE_W-1:0];
`else
                {nxt_h, nxt_l} = full + PTR_W'(extend_offset(offset, op == OP_IDXS));
`endif
            end
            OP_NOP:  ;
            default: ;
        endcase
    end

`ifdef PTR_BANK_FIXUP_EN
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FIXUP = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] fix_sel;
    logic             fix_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            fix_sel <= '0;
            fix_dec <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && state_nxt == ST_FIXUP) begin
                fix_sel <= wr_sel;
                fix_dec <= cross_dn;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        op_ready  = 1'b0;
        busy_sel  = '0;
        case (state)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (accept && sel_ok && crossing) state_nxt = ST_FIXUP;
            end
            ST_FIXUP: begin
                busy_sel  = fix_sel;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
`else
    assign op_ready = 1'b1;
    assign busy_sel = '0;
`endif

    // ---- register update / page_cross stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_l[i] <= '0;
                reg_h[i] <= '0;
            end
            page_cross_p1 <= 1'b0;
        end else begin
            page_cross_p1 <= accept & sel_ok & crossing;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (accept && wr_sel == SEL_W'(i)) begin
                    reg_l[i] <= nxt_l;
                    reg_h[i] <= nxt_h;
                end
`ifdef PTR_BANK_FIXUP_EN
                // No op can be accepted in FIXUP, so this never collides
                // with the write above.
                if (state == ST_FIXUP && fix_sel == SEL_W'(i)) begin
                    reg_h[i] <= fix_dec ? reg_h[i] - BYTE_W'(1)
                                        : reg_h[i] + BYTE_W'(1);
                end
`endif
            end
        end
    end

    assign page_cross = page_cross_p1;

endmodule

// File: tb/tb_ptr_reg_bank.sv
module tb_ptr_reg_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op;
    logic [1:0] wr_sel;
    logic [7:0] din_l;
    logic [7:0] din_h;
    logic [7:0] offset;
    logic [1:0] rd_sel;
    logic [7:0] addr_l;
    logic [7:0] addr_h;
    logic       page_cross;
    logic [1:0] busy_sel;

    int tests = 0;
    int fails = 0;

    ptr_reg_bank #(.NUM_REGS(3), .BYTE_W(8), .SEL_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op        (op),
        .wr_sel    (wr_sel),
        .din_l     (din_l),
        .din_h     (din_h),
        .offset    (offset),
        .rd_sel    (rd_sel),
        .addr_l    (addr_l),
        .addr_h    (addr_h),
        .page_cross(page_cross),
        .busy_sel  (busy_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        pc;
        logic        rdy;
        logic [1:0]  busy;
        string       name;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  ws;
        logic [15:0] din;
        logic [7:0]  off;
        logic [1:0]  rd;
        logic [15:0] exp_addr;
        logic        exp_pc;
        string       name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic drive(input logic [2:0] o, input logic [1:0] ws,
                         input logic [15:0] d, input logic [7:0] off,
                         input logic [1:0] rd, input logic v);
        op       = o;
        wr_sel   = ws;
        din_h    = d[15:8];
        din_l    = d[7:0];
        offset   = off;
        rd_sel   = rd;
        op_valid = v;
    endtask

    task automatic push(input logic [15:0] a, input logic pc, input logic rdy,
                        input logic [1:0] busy, input string name);
        exp_t e;
        e.addr = a;
        e.pc   = pc;
        e.rdy  = rdy;
        e.busy = busy;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_pop;
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty: no expected entry for DUT output");
        end else begin
            e = sb.pop_front();
            if ({addr_h, addr_l} !== e.addr || page_cross !== e.pc ||
                op_ready !== e.rdy || busy_sel !== e.busy) begin
                fails++;
                $display("FAIL %s: got addr=%h pc=%b rdy=%b busy=%0d, required addr=%h pc=%b rdy=%b busy=%0d",
                         e.name, {addr_h, addr_l}, page_cross, op_ready, busy_sel,
                         e.addr, e.pc, e.rdy, e.busy);
            end
        end
    endtask

    task automatic add_vec(input logic [2:0] o, input logic [1:0] ws,
                           input logic [15:0] d, input logic [7:0] off,
                           input logic [1:0] rd, input logic [15:0] ea,
                           input logic epc, input string name);
        vec_t v;
        v.op = o; v.ws = ws; v.din = d; v.off = off; v.rd = rd;
        v.exp_addr = ea; v.exp_pc = epc; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        // Single-cycle operations: {op, wr_sel, din, offset, rd_sel, expected addr, page_cross}
        add_vec(3'd3, 2'd0, 16'h1234, 8'h00, 2'd0, 16'h1234, 1'b0, "ldw_r0");
        add_vec(3'd3, 2'd1, 16'h00FF, 8'h00, 2'd1, 16'h00FF, 1'b0, "ldw_r1");
        add_vec(3'd4, 2'd1, 16'h0000, 8'h00, 2'd1, 16'h0100, 1'b0, "inc_00ff");
        add_vec(3'd3, 2'd2, 16'h0000, 8'h00, 2'd2, 16'h0000, 1'b0, "ldw_r2_zero");
        add_vec(3'd5, 2'd2, 16'h0000, 8'h00, 2'd2, 16'hFFFF, 1'b0, "dec_0000");
        add_vec(3'd4, 2'd2, 16'h0000, 8'h00, 2'd2, 16'h0000, 1'b0, "inc_ffff");
        add_vec(3'd1, 2'd0, 16'h99AB, 8'h00, 2'd0, 16'h12AB, 1'b0, "ldl_r0");
        add_vec(3'd2, 2'd0, 16'h5677, 8'h00, 2'd0, 16'h56AB, 1'b0, "ldh_r0");
        add_vec(3'd3, 2'd0, 16'h3005, 8'h00, 2'd0, 16'h3005, 1'b0, "ldw_r0_3005");
        add_vec(3'd7, 2'd0, 16'h0000, 8'h7F, 2'd0, 16'h3084, 1'b0, "idxs_pos_nocross");
        add_vec(3'd6, 2'd1, 16'h0000, 8'h10, 2'd1, 16'h0110, 1'b0, "idxu_nocross");
        add_vec(3'd7, 2'd1, 16'h0000, 8'hFF, 2'd1, 16'h010F, 1'b0, "idxs_neg_nocross");
        add_vec(3'd3, 2'd3, 16'h9999, 8'h00, 2'd0, 16'h3084, 1'b0, "wr_sel_oob");
        add_vec(3'd0, 2'd2, 16'hFFFF, 8'h00, 2'd2, 16'h0000, 1'b0, "nop_r2");
        add_vec(3'd0, 2'd0, 16'h0000, 8'h00, 2'd1, 16'h010F, 1'b0, "rd_r1_view");

        rst_n = 1'b0;
        drive(3'd0, 2'd0, 16'h0000, 8'h00, 2'd0, 1'b0);
        #12;
        push(16'h0000, 1'b0, 1'b1, 2'd0, "reset_state");
        check_pop;
        rst_n = 1'b1;
        step;

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].ws, vecs[i].din, vecs[i].off, vecs[i].rd, 1'b1);
            push(vecs[i].exp_addr, vecs[i].exp_pc, 1'b1, 2'd0, vecs[i].name);
            step;
            check_pop;
        end

        // IDXU crossing on r2 with an INC held behind it.
        drive(3'd3, 2'd2, 16'h20F0, 8'h00, 2'd2, 1'b1);
        push(16'h20F0, 1'b0, 1'b1, 2'd0, "ldw_r2_20f0");
        step; check_pop;
        drive(3'd6, 2'd2, 16'h0000, 8'h20, 2'd2, 1'b1);
`ifdef PTR_BANK_FIXUP_EN
        push(16'h2010, 1'b1, 1'b0, 2'd2, "idxu_cross_c1");
        step; check_pop;
        drive(3'd4, 2'd2, 16'h0000, 8'h00, 2'd2, 1'b1);
        push(16'h2110, 1'b0, 1'b1, 2'd0, "idxu_cross_c2_inc_held");
        step; check_pop;
        push(16'h2111, 1'b0, 1'b1, 2'd0, "held_inc_accepted");
        step; check_pop;
`else
        push(16'h2110, 1'b1, 1'b1, 2'd0, "idxu_cross_1cyc");
        step; check_pop;
        drive(3'd4, 2'd2, 16'h0000, 8'h00, 2'd2, 1'b1);
        push(16'h2111, 1'b0, 1'b1, 2'd0, "inc_after_idxu");
        step; check_pop;
`endif
        op_valid = 1'b0;
        push(16'h2111, 1'b0, 1'b1, 2'd0, "idle_after_inc");
        step; check_pop;

        // IDXS borrow on r0: 0x3005 + (-16).
        drive(3'd3, 2'd0, 16'h3005, 8'h00, 2'd0, 1'b1);
        push(16'h3005, 1'b0, 1'b1, 2'd0, "ldw_r0_3005_b");
        step; check_pop;
        drive(3'd7, 2'd0, 16'h0000, 8'hF0, 2'd0, 1'b1);
`ifdef PTR_BANK_FIXUP_EN
        push(16'h30F5, 1'b1, 1'b0, 2'd0, "idxs_borrow_c1");
        step; check_pop;
        op_valid = 1'b0;
        push(16'h2FF5, 1'b0, 1'b1, 2'd0, "idxs_borrow_c2");
        step; check_pop;
`else
        push(16'h2FF5, 1'b1, 1'b1, 2'd0, "idxs_borrow_1cyc");
        step; check_pop;
        op_valid = 1'b0;
`endif
        push(16'h2FF5, 1'b0, 1'b1, 2'd0, "idxs_borrow_stable");
        step; check_pop;

        // Reset pulse straight after a crossing IDXU.
        drive(3'd3, 2'd2, 16'h20F0, 8'h00, 2'd2, 1'b1);
        push(16'h20F0, 1'b0, 1'b1, 2'd0, "ldw_r2_20f0_b");
        step; check_pop;
        drive(3'd6, 2'd2, 16'h0000, 8'h20, 2'd2, 1'b1);
`ifdef PTR_BANK_FIXUP_EN
        push(16'h2010, 1'b1, 1'b0, 2'd2, "idxu_cross_pre_reset");
`else
        push(16'h2110, 1'b1, 1'b1, 2'd0, "idxu_cross_pre_reset");
`endif
        step; check_pop;
        op_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        push(16'h0000, 1'b0, 1'b1, 2'd0, "reset_mid_fixup_r2");
        check_pop;
        rd_sel = 2'd0;
        #1;
        push(16'h0000, 1'b0, 1'b1, 2'd0, "reset_mid_fixup_r0");
        check_pop;
        rd_sel = 2'd2;
        #2 rst_n = 1'b1;
        push(16'h0000, 1'b0, 1'b1, 2'd0, "no_fixup_after_reset");
        step; check_pop;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
